// File: rtl/dispatch_pkg.sv
// Shared widths, opType encoding and RV32I opcodes for the issue stage
// and its neighbours (RS, EX, ROB, LSB).
package dispatch_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int IMM_W  = 32;
  localparam int ADDR_W = 32;
  localparam int OP_W   = 6;

  localparam logic [TAG_W-1:0] emptyTag = '0;

  typedef enum logic [OP_W-1:0] {
    OP_EMPTY, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } op_t;

  localparam op_t emptyOp = OP_EMPTY;

  localparam logic UNIT_RS  = 1'b0;
  localparam logic UNIT_LSB = 1'b1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } operand_t;

  typedef struct packed {
    logic [TAG_W-1:0]  dest;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  t1;
    logic [DATA_W-1:0] d1;
    logic [TAG_W-1:0]  t2;
    logic [DATA_W-1:0] d2;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] pc;
  } issue_pkt_t;

  // Regfile value, then same-cycle CDB, then ROB ready data, else wait on tag.
  function automatic operand_t resolve(
    input logic              use_s,
    input logic [4:0]        addr,
    input logic [TAG_W-1:0]  rtag,
    input logic [DATA_W-1:0] rdata,
    input logic [TAG_W-1:0]  cdb_tag,
    input logic [DATA_W-1:0] cdb_data,
    input logic              rob_rdy,
    input logic [DATA_W-1:0] rob_data
  );
    operand_t r;
    r.tag  = emptyTag;
    r.data = '0;
    if (use_s && addr != 5'd0) begin
      if (rtag == emptyTag)     r.data = rdata;
      else if (cdb_tag == rtag) r.data = cdb_data;
      else if (rob_rdy)         r.data = rob_data;
      else                      r.tag  = rtag;
    end
    return r;
  endfunction

endpackage

// File: rtl/dispatch_inst_decode.sv
// RV32I decoder: opType, immediate, register fields, source-use flags
// and target unit (LSB for loads/stores, RS otherwise).
module inst_decode
  import dispatch_pkg::*;
(
  input  logic [31:0]      inst_i,
  output logic [OP_W-1:0]  op_o,
  output logic [IMM_W-1:0] imm_o,
  output logic [4:0]       rd_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic             use_rs1_o,
  output logic             use_rs2_o,
  output logic             unit_o
);

  logic [6:0]       opc;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [IMM_W-1:0] imm_i;
  logic [IMM_W-1:0] imm_s;
  logic [IMM_W-1:0] imm_b;
  logic [IMM_W-1:0] imm_u;
  logic [IMM_W-1:0] imm_j;

  assign opc   = inst_i[6:0];
  assign f3    = inst_i[14:12];
  assign f7    = inst_i[31:25];
  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                  inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'd0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                  inst_i[20], inst_i[30:21], 1'b0};

  always_comb begin
    op_o      = emptyOp;
    imm_o     = '0;
    rd_o      = inst_i[11:7];
    rs1_o     = inst_i[19:15];
    rs2_o     = inst_i[24:20];
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    unit_o    = UNIT_RS;
    unique case (1'b1)
      opc == OPC_LUI: begin
        op_o  = OP_LUI;
        imm_o = imm_u;
      end
      opc == OPC_AUIPC: begin
        op_o  = OP_AUIPC;
        imm_o = imm_u;
      end
      opc == OPC_JAL: begin
        op_o  = OP_JAL;
        imm_o = imm_j;
      end
      opc == OPC_JALR: begin
        if (f3 == 3'b000) op_o = OP_JALR;
        imm_o     = imm_i;
        use_rs1_o = 1'b1;
      end
      opc == OPC_BRANCH: begin
        imm_o     = imm_b;
        rd_o      = 5'd0;
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
        case (f3)
          3'b000:  op_o = OP_BEQ;
          3'b001:  op_o = OP_BNE;
          3'b100:  op_o = OP_BLT;
          3'b101:  op_o = OP_BGE;
          3'b110:  op_o = OP_BLTU;
          3'b111:  op_o = OP_BGEU;
          default: op_o = emptyOp;
        endcase
      end
      opc == OPC_LOAD: begin
        imm_o     = imm_i;
        use_rs1_o = 1'b1;
        unit_o    = UNIT_LSB;
        case (f3)
          3'b000:  op_o = OP_LB;
          3'b001:  op_o = OP_LH;
          3'b010:  op_o = OP_LW;
          3'b100:  op_o = OP_LBU;
          3'b101:  op_o = OP_LHU;
          default: op_o = emptyOp;
        endcase
      end
      opc == OPC_STORE: begin
        imm_o     = imm_s;
        rd_o      = 5'd0;
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
        unit_o    = UNIT_LSB;
        case (f3)
          3'b000:  op_o = OP_SB;
          3'b001:  op_o = OP_SH;
          3'b010:  op_o = OP_SW;
          default: op_o = emptyOp;
        endcase
      end
      opc == OPC_OPIMM: begin
        imm_o     = imm_i;
        use_rs1_o = 1'b1;
        case (f3)
          3'b000:  op_o = OP_ADDI;
          3'b010:  op_o = OP_SLTI;
          3'b011:  op_o = OP_SLTIU;
          3'b100:  op_o = OP_XORI;
          3'b110:  op_o = OP_ORI;
          3'b111:  op_o = OP_ANDI;
          3'b001:  op_o = (f7 == 7'h00) ? OP_SLLI : emptyOp;
          3'b101:  op_o = (f7 == 7'h00) ? OP_SRLI :
                          (f7 == 7'h20) ? OP_SRAI : emptyOp;
          default: op_o = emptyOp;
        endcase
        if (f3 == 3'b001 || f3 == 3'b101) imm_o = {27'd0, inst_i[24:20]};
      end
      opc == OPC_OP: begin
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
        case ({f7, f3})
          10'b0000000_000: op_o = OP_ADD;
          10'b0100000_000: op_o = OP_SUB;
          10'b0000000_001: op_o = OP_SLL;
          10'b0000000_010: op_o = OP_SLT;
          10'b0000000_011: op_o = OP_SLTU;
          10'b0000000_100: op_o = OP_XOR;
          10'b0000000_101: op_o = OP_SRL;
          10'b0100000_101: op_o = OP_SRA;
          10'b0000000_110: op_o = OP_OR;
          10'b0000000_111: op_o = OP_AND;
          default:         op_o = emptyOp;
        endcase
      end
      default: ;
    endcase
    // Anything unrecognised becomes a side-effect-free bubble on the RS.
    if (op_o == emptyOp) begin
      imm_o     = '0;
      rd_o      = 5'd0;
      use_rs1_o = 1'b0;
      use_rs2_o = 1'b0;
      unit_o    = UNIT_RS;
    end
  end

endmodule

// File: rtl/dispatch.sv
// Issue stage: decode, ROB allocate, rename, resolve operands and send one
// registered packet per cycle to the RS or the LSB.
module dispatch
  import dispatch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              inst_valid,
  input  logic [31:0]       inst,
  input  logic [ADDR_W-1:0] inst_pc,
  output logic              inst_ack,
  output logic [4:0]        reg_rs1_addr,
  output logic [4:0]        reg_rs2_addr,
  input  logic [TAG_W-1:0]  reg_rs1_tag,
  input  logic [TAG_W-1:0]  reg_rs2_tag,
  input  logic [DATA_W-1:0] reg_rs1_data,
  input  logic [DATA_W-1:0] reg_rs2_data,
  input  logic              rob_idle,
  input  logic [TAG_W-1:0]  rob_free_tag,
  output logic [TAG_W-1:0]  rob_q1_tag,
  output logic [TAG_W-1:0]  rob_q2_tag,
  input  logic              rob_q1_ready,
  input  logic              rob_q2_ready,
  input  logic [DATA_W-1:0] rob_q1_data,
  input  logic [DATA_W-1:0] rob_q2_data,
  output logic              rob_issue,
  output logic [4:0]        rob_rd,
  output logic [OP_W-1:0]   rob_op,
  output logic              rename_en,
  output logic [4:0]        rename_rd,
  output logic [TAG_W-1:0]  rename_tag,
  input  logic [TAG_W-1:0]  tag_renew,
  input  logic [DATA_W-1:0] data_renew,
  input  logic              rs_idle,
  input  logic              lsb_idle,
  output logic              if_issue_rs,
  output logic              if_issue_lsb,
  output logic [TAG_W-1:0]  dest_out,
  output logic [OP_W-1:0]   op_type_out,
  output logic [TAG_W-1:0]  tag_rs1_out,
  output logic [DATA_W-1:0] data_rs1_out,
  output logic [TAG_W-1:0]  tag_rs2_out,
  output logic [DATA_W-1:0] data_rs2_out,
  output logic [IMM_W-1:0]  imm_out,
  output logic [ADDR_W-1:0] pc_out
);

  logic [OP_W-1:0]  dec_op;
  logic [IMM_W-1:0] dec_imm;
  logic [4:0]       dec_rd;
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic             dec_u1;
  logic             dec_u2;
  logic             dec_unit;

  inst_decode u_dec (
    .inst_i    (inst),
    .op_o      (dec_op),
    .imm_o     (dec_imm),
    .rd_o      (dec_rd),
    .rs1_o     (dec_rs1),
    .rs2_o     (dec_rs2),
    .use_rs1_o (dec_u1),
    .use_rs2_o (dec_u2),
    .unit_o    (dec_unit)
  );

  logic       issue_rs_q, issue_rs_d;
  logic       issue_lsb_q, issue_lsb_d;
  issue_pkt_t pkt_q, pkt_d;
  logic       target_idle;
  logic       pend_target;
  logic       accept;
  operand_t   src1;
  operand_t   src2;

  // The last pulse doubles as the pending flag: the target's idle
  // signal lags the write it just received by one cycle.
  assign target_idle = (dec_unit == UNIT_LSB) ? lsb_idle : rs_idle;
  assign pend_target = (dec_unit == UNIT_LSB) ? issue_lsb_q : issue_rs_q;
  assign accept = rdy && !rst && !clear && inst_valid && rob_idle
                  && target_idle && !pend_target;

  assign src1 = resolve(dec_u1, dec_rs1, reg_rs1_tag, reg_rs1_data,
                        tag_renew, data_renew, rob_q1_ready, rob_q1_data);
  assign src2 = resolve(dec_u2, dec_rs2, reg_rs2_tag, reg_rs2_data,
                        tag_renew, data_renew, rob_q2_ready, rob_q2_data);

  assign inst_ack     = accept;
  assign reg_rs1_addr = dec_rs1;
  assign reg_rs2_addr = dec_rs2;
  assign rob_q1_tag   = reg_rs1_tag;
  assign rob_q2_tag   = reg_rs2_tag;
  assign rob_issue    = accept;
  assign rob_rd       = dec_rd;
  assign rob_op       = dec_op;
  assign rename_en    = accept && (dec_rd != 5'd0);
  assign rename_rd    = dec_rd;
  assign rename_tag   = rob_free_tag;

  always_comb begin
    issue_rs_d  = issue_rs_q;
    issue_lsb_d = issue_lsb_q;
    pkt_d       = pkt_q;
    if (rdy) begin
      issue_rs_d  = accept && (dec_unit == UNIT_RS);
      issue_lsb_d = accept && (dec_unit == UNIT_LSB);
      if (accept) begin
        pkt_d = '{dest: rob_free_tag, op: dec_op,
                  t1: src1.tag, d1: src1.data,
                  t2: src2.tag, d2: src2.data,
                  imm: dec_imm, pc: inst_pc};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_rs_q  <= 1'b0;
      issue_lsb_q <= 1'b0;
      pkt_q       <= '0;
    end else begin
      issue_rs_q  <= issue_rs_d;
      issue_lsb_q <= issue_lsb_d;
      pkt_q       <= pkt_d;
    end
  end

  assign if_issue_rs  = issue_rs_q;
  assign if_issue_lsb = issue_lsb_q;
  assign dest_out     = pkt_q.dest;
  assign op_type_out  = pkt_q.op;
  assign tag_rs1_out  = pkt_q.t1;
  assign data_rs1_out = pkt_q.d1;
  assign tag_rs2_out  = pkt_q.t2;
  assign data_rs2_out = pkt_q.d2;
  assign imm_out      = pkt_q.imm;
  assign pc_out       = pkt_q.pc;

endmodule

// File: tb/tb_dispatch.sv
// Self-checking bench for dispatch: directed scenarios plus a randomized
// run against a behavioural model of accept, operand resolution and issue.
`timescale 1ns/1ps
module tb_dispatch;
  import dispatch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, rdy, clear, inst_valid;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ack;
  logic [4:0]        reg_rs1_addr, reg_rs2_addr;
  logic [TAG_W-1:0]  reg_rs1_tag, reg_rs2_tag;
  logic [DATA_W-1:0] reg_rs1_data, reg_rs2_data;
  logic              rob_idle;
  logic [TAG_W-1:0]  rob_free_tag, rob_q1_tag, rob_q2_tag;
  logic              rob_q1_ready, rob_q2_ready;
  logic [DATA_W-1:0] rob_q1_data, rob_q2_data;
  logic              rob_issue;
  logic [4:0]        rob_rd;
  logic [OP_W-1:0]   rob_op;
  logic              rename_en;
  logic [4:0]        rename_rd;
  logic [TAG_W-1:0]  rename_tag, tag_renew;
  logic [DATA_W-1:0] data_renew;
  logic              rs_idle, lsb_idle, if_issue_rs, if_issue_lsb;
  logic [TAG_W-1:0]  dest_out, tag_rs1_out, tag_rs2_out;
  logic [OP_W-1:0]   op_type_out;
  logic [DATA_W-1:0] data_rs1_out, data_rs2_out;
  logic [IMM_W-1:0]  imm_out;
  logic [ADDR_W-1:0] pc_out;

  dispatch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ack(inst_ack),
    .reg_rs1_addr(reg_rs1_addr), .reg_rs2_addr(reg_rs2_addr),
    .reg_rs1_tag(reg_rs1_tag), .reg_rs2_tag(reg_rs2_tag),
    .reg_rs1_data(reg_rs1_data), .reg_rs2_data(reg_rs2_data),
    .rob_idle(rob_idle), .rob_free_tag(rob_free_tag),
    .rob_q1_tag(rob_q1_tag), .rob_q2_tag(rob_q2_tag),
    .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
    .rob_q1_data(rob_q1_data), .rob_q2_data(rob_q2_data),
    .rob_issue(rob_issue), .rob_rd(rob_rd), .rob_op(rob_op),
    .rename_en(rename_en), .rename_rd(rename_rd),
    .rename_tag(rename_tag),
    .tag_renew(tag_renew), .data_renew(data_renew),
    .rs_idle(rs_idle), .lsb_idle(lsb_idle),
    .if_issue_rs(if_issue_rs), .if_issue_lsb(if_issue_lsb),
    .dest_out(dest_out), .op_type_out(op_type_out),
    .tag_rs1_out(tag_rs1_out), .data_rs1_out(data_rs1_out),
    .tag_rs2_out(tag_rs2_out), .data_rs2_out(data_rs2_out),
    .imm_out(imm_out), .pc_out(pc_out)
  );

  localparam int K_ADDI = 0, K_ADD = 1, K_SUB = 2, K_LW = 3;
  localparam int K_SW = 4, K_BEQ = 5, K_LUI = 6, K_BAD = 7;

  int checks = 0;
  int errors = 0;

  logic [OP_W-1:0]  e_op;
  logic [IMM_W-1:0] e_imm;
  logic [4:0]       e_rd, e_rs1, e_rs2;
  logic             e_u1, e_u2, e_lsb;

  logic [145:0] pkt_now;
  assign pkt_now = {dest_out, op_type_out, tag_rs1_out, data_rs1_out,
                    tag_rs2_out, data_rs2_out, imm_out, pc_out};

  task automatic set_idle();
    rdy = 1'b1; clear = 1'b0; inst_valid = 1'b0; inst = '0; inst_pc = '0;
    reg_rs1_tag = '0; reg_rs2_tag = '0;
    reg_rs1_data = '0; reg_rs2_data = '0;
    rob_idle = 1'b1; rob_free_tag = 4'd1;
    rob_q1_ready = 1'b0; rob_q2_ready = 1'b0;
    rob_q1_data = '0; rob_q2_data = '0;
    tag_renew = '0; data_renew = '0;
    rs_idle = 1'b1; lsb_idle = 1'b1;
  endtask

  // Encodes an instruction and records what the decoder should report.
  task automatic load_inst(input int k, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input int imm);
    logic [31:0] im;
    logic [31:0] v;
    im = 32'(imm);
    v = $urandom();
    e_rs1 = rs1; e_rs2 = rs2; e_rd = 5'd0; e_imm = im;
    e_u1 = 1'b0; e_u2 = 1'b0; e_lsb = 1'b0;
    case (k)
      K_ADDI: begin
        inst = {im[11:0], rs1, 3'b000, rd, 7'b0010011};
        e_op = OP_ADDI; e_rd = rd; e_u1 = 1'b1;
      end
      K_ADD, K_SUB: begin
        inst = {(k == K_SUB) ? 7'h20 : 7'h00, rs2, rs1, 3'b000, rd,
                7'b0110011};
        e_op = (k == K_SUB) ? OP_SUB : OP_ADD;
        e_rd = rd; e_u1 = 1'b1; e_u2 = 1'b1; e_imm = '0;
      end
      K_LW: begin
        inst = {im[11:0], rs1, 3'b010, rd, 7'b0000011};
        e_op = OP_LW; e_rd = rd; e_u1 = 1'b1; e_lsb = 1'b1;
      end
      K_SW: begin
        inst = {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
        e_op = OP_SW; e_u1 = 1'b1; e_u2 = 1'b1; e_lsb = 1'b1;
      end
      K_BEQ: begin
        inst = {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11],
                7'b1100011};
        e_op = OP_BEQ; e_u1 = 1'b1; e_u2 = 1'b1;
      end
      K_LUI: begin
        inst = {im[19:0], rd, 7'b0110111};
        e_op = OP_LUI; e_rd = rd; e_imm = im << 12;
      end
      default: begin
        inst = {v[31:7], 7'b1111111};
        e_op = OP_EMPTY; e_imm = '0;
      end
    endcase
  endtask

  function automatic logic [TAG_W+DATA_W-1:0] ref_src(
    input logic use_s, input logic [4:0] a,
    input logic [TAG_W-1:0] rt, input logic [DATA_W-1:0] rv,
    input logic [TAG_W-1:0] ct, input logic [DATA_W-1:0] cv,
    input logic qr, input logic [DATA_W-1:0] qv);
    if (!use_s || a == 5'd0) return '0;
    if (rt == 4'd0) return {4'd0, rv};
    if (ct == rt) return {4'd0, cv};
    if (qr) return {4'd0, qv};
    return {rt, 32'd0};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    load_inst(K_ADDI, 5'd1, 5'd0, 5'd0, 5);
    inst_valid = 1'b1;
    #1;
    checks++;
    if ({inst_ack, rename_en, rob_issue} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ack got %b exp 000",
               {inst_ack, rename_en, rob_issue});
    end
    @(posedge clk); #1;
    checks++;
    if ({if_issue_rs, if_issue_lsb, pkt_now} !== '0) begin
      errors++;
      $display("FAIL reset_state got %b %b %h exp all zero",
               if_issue_rs, if_issue_lsb, pkt_now);
    end
    @(negedge clk);
    rst = 1'b0;
    inst_valid = 1'b0;
  endtask

  task automatic test_addi();
    @(negedge clk);
    load_inst(K_ADDI, 5'd1, 5'd0, 5'd0, 5);
    inst_pc = 32'h0; rob_free_tag = 4'd3; inst_valid = 1'b1;
    reg_rs1_tag = 4'd7; reg_rs1_data = 32'hDEAD;
    #1;
    checks++;
    if ({inst_ack, rename_en, rename_rd, rename_tag} !== {2'b11, 5'd1, 4'd3})
    begin
      errors++;
      $display("FAIL addi_rename got %b %b %0d %0d exp 1 1 1 3",
               inst_ack, rename_en, rename_rd, rename_tag);
    end
    @(posedge clk); #1;
    checks++;
    if ({if_issue_rs, if_issue_lsb, dest_out, tag_rs1_out, data_rs1_out,
         imm_out, pc_out, op_type_out} !==
        {2'b10, 4'd3, 4'd0, 32'd0, 32'd5, 32'd0, OP_ADDI}) begin
      errors++;
      $display("FAIL addi_issue got rs=%b lsb=%b dest=%0d t1=%0d d1=%h imm=%h pc=%h op=%0d",
               if_issue_rs, if_issue_lsb, dest_out, tag_rs1_out,
               data_rs1_out, imm_out, pc_out, op_type_out);
    end
    @(negedge clk);
    inst_valid = 1'b0;
    reg_rs1_tag = '0;
    @(posedge clk); #1;
    checks++;
    if ({if_issue_rs, imm_out, dest_out} !== {1'b0, 32'd5, 4'd3}) begin
      errors++;
      $display("FAIL idle_hold got rs=%b imm=%h dest=%0d exp 0 5 3",
               if_issue_rs, imm_out, dest_out);
    end
  endtask

  task automatic test_add_dep();
    @(negedge clk);
    load_inst(K_ADD, 5'd2, 5'd1, 5'd1, 0);
    reg_rs1_tag = 4'd3; reg_rs2_tag = 4'd3;
    reg_rs1_data = 32'h99; reg_rs2_data = 32'h99;
    rob_free_tag = 4'd4; inst_valid = 1'b1;
    #1;
    checks++;
    if ({inst_ack, rob_q1_tag, rob_q2_tag} !== {1'b1, 4'd3, 4'd3}) begin
      errors++;
      $display("FAIL dep_query got ack=%b q1=%0d q2=%0d exp 1 3 3",
               inst_ack, rob_q1_tag, rob_q2_tag);
    end
    @(posedge clk); #1;
    checks++;
    if ({tag_rs1_out, data_rs1_out, tag_rs2_out, data_rs2_out} !==
        {4'd3, 32'd0, 4'd3, 32'd0}) begin
      errors++;
      $display("FAIL dep_wait got t1=%0d d1=%h t2=%0d d2=%h exp 3 0 3 0",
               tag_rs1_out, data_rs1_out, tag_rs2_out, data_rs2_out);
    end
    @(negedge clk);
    inst_valid = 1'b0;
    @(negedge clk);
    tag_renew = 4'd3; data_renew = 32'h2A; inst_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({if_issue_rs, tag_rs1_out, data_rs1_out, tag_rs2_out,
         data_rs2_out} !== {1'b1, 4'd0, 32'h2A, 4'd0, 32'h2A}) begin
      errors++;
      $display("FAIL dep_bypass got rs=%b t1=%0d d1=%h t2=%0d d2=%h",
               if_issue_rs, tag_rs1_out, data_rs1_out, tag_rs2_out,
               data_rs2_out);
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_back_to_back();
    int nack;
    int idx;
    logic [3:0] seq;
    logic [2:0] rsq, lsbq;
    int kinds[3];
    kinds = '{K_ADDI, K_LW, K_ADDI};
    nack = 0;
    @(negedge clk);
    load_inst(K_ADDI, 5'd3, 5'd0, 5'd0, 1);
    inst_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 if (inst_ack) nack++;
      @(posedge clk); #1 seq[i] = if_issue_rs;
      @(negedge clk);
      if (nack >= 2) inst_valid = 1'b0;
    end
    checks++;
    if (seq !== 4'b0101 || nack != 2) begin
      errors++;
      $display("FAIL same_unit_spacing got seq=%b acks=%0d exp 0101 2",
               seq, nack);
    end
    idx = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (idx < 3) begin
        load_inst(kinds[idx], 5'd4, 5'd0, 5'd0, i);
        inst_valid = 1'b1;
      end
      #1 if (inst_ack) idx++;
      @(posedge clk); #1;
      rsq[i] = if_issue_rs;
      lsbq[i] = if_issue_lsb;
    end
    checks++;
    if (idx != 3 || rsq !== 3'b101 || lsbq !== 3'b010) begin
      errors++;
      $display("FAIL alternate got acks=%0d rs=%b lsb=%b exp 3 101 010",
               idx, rsq, lsbq);
    end
    @(negedge clk);
    inst_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    @(negedge clk);
    load_inst(K_ADDI, 5'd5, 5'd0, 5'd0, 9);
    rob_idle = 1'b0; inst_valid = 1'b1;
    #1;
    checks++;
    if ({inst_ack, rename_en, rob_issue} !== 3'b000) begin
      errors++;
      $display("FAIL rob_full got %b exp 000",
               {inst_ack, rename_en, rob_issue});
    end
    @(posedge clk); #1;
    checks++;
    if (if_issue_rs !== 1'b0) begin
      errors++;
      $display("FAIL rob_full_pulse got %b exp 0", if_issue_rs);
    end
    @(negedge clk);
    rob_idle = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if_issue_rs !== 1'b1 || imm_out !== 32'd9) begin
      errors++;
      $display("FAIL rob_release got rs=%b imm=%h exp 1 9",
               if_issue_rs, imm_out);
    end
    @(negedge clk);
    load_inst(K_SW, 5'd0, 5'd2, 5'd0, -8);
    lsb_idle = 1'b0; reg_rs1_data = 32'h100;
    #1;
    checks++;
    if ({inst_ack, rename_en} !== 2'b00) begin
      errors++;
      $display("FAIL lsb_full got %b exp 00", {inst_ack, rename_en});
    end
    @(posedge clk); #1;
    checks++;
    if (if_issue_lsb !== 1'b0) begin
      errors++;
      $display("FAIL lsb_full_pulse got %b exp 0", if_issue_lsb);
    end
    @(negedge clk);
    lsb_idle = 1'b1;
    #1;
    checks++;
    if ({inst_ack, rename_en} !== 2'b10) begin
      errors++;
      $display("FAIL sw_ack got %b exp 10", {inst_ack, rename_en});
    end
    @(posedge clk); #1;
    checks++;
    if ({if_issue_lsb, if_issue_rs, imm_out, data_rs1_out, tag_rs2_out,
         data_rs2_out} !== {2'b10, 32'hFFFF_FFF8, 32'h100, 4'd0, 32'd0})
    begin
      errors++;
      $display("FAIL sw_issue got lsb=%b rs=%b imm=%h d1=%h t2=%0d d2=%h",
               if_issue_lsb, if_issue_rs, imm_out, data_rs1_out,
               tag_rs2_out, data_rs2_out);
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_clear();
    @(negedge clk);
    load_inst(K_ADDI, 5'd6, 5'd0, 5'd0, 1);
    inst_valid = 1'b1;
    @(negedge clk);
    load_inst(K_LW, 5'd7, 5'd0, 5'd0, 4);
    clear = 1'b1;
    #1;
    checks++;
    if ({inst_ack, rename_en, rob_issue, if_issue_rs} !== 4'b0001) begin
      errors++;
      $display("FAIL clear_comb got %b exp 0001",
               {inst_ack, rename_en, rob_issue, if_issue_rs});
    end
    @(posedge clk); #1;
    checks++;
    if ({if_issue_rs, if_issue_lsb} !== 2'b00) begin
      errors++;
      $display("FAIL clear_pulse got %b exp 00",
               {if_issue_rs, if_issue_lsb});
    end
    @(negedge clk);
    clear = 1'b0;
    load_inst(K_ADDI, 5'd6, 5'd0, 5'd0, 2);
    #1;
    checks++;
    if (inst_ack !== 1'b1) begin
      errors++;
      $display("FAIL clear_pend got ack=%b exp 1", inst_ack);
    end
    @(posedge clk); #1;
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    load_inst(K_SW, 5'd0, 5'd1, 5'd2, 12);
    reg_rs2_data = 32'h55; inst_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if_issue_lsb !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup got lsb=%b exp 1", if_issue_lsb);
    end
    @(negedge clk);
    rst = 1'b1;
    load_inst(K_ADDI, 5'd8, 5'd0, 5'd0, 3);
    #1;
    checks++;
    if (inst_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ack got %b exp 0", inst_ack);
    end
    @(posedge clk); #1;
    checks++;
    if ({if_issue_rs, if_issue_lsb, pkt_now} !== '0) begin
      errors++;
      $display("FAIL rst_mid_state got %b %b %h exp all zero",
               if_issue_rs, if_issue_lsb, pkt_now);
    end
    @(negedge clk);
    rst = 1'b0;
    set_idle();
  endtask

  task automatic test_random();
    logic         m_rs, m_lsb, e_acc;
    logic [145:0] m_pkt;
    logic [35:0]  s1, s2;
    int           k, imm, r;
    m_rs = 1'b0; m_lsb = 1'b0; m_pkt = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      k = $urandom_range(0, 7);
      case (k)
        K_BEQ:   imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
        K_LUI:   imm = int'($urandom_range(0, 20'hFFFFF));
        default: imm = int'($urandom_range(0, 4095)) - 2048;
      endcase
      load_inst(k, 5'($urandom_range(0, 31)),
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                imm);
      inst_pc      = $urandom();
      rdy          = ($urandom_range(0, 9) != 0);
      clear        = ($urandom_range(0, 14) == 0);
      inst_valid   = ($urandom_range(0, 4) != 0);
      rob_idle     = ($urandom_range(0, 5) != 0);
      rs_idle      = ($urandom_range(0, 4) != 0);
      lsb_idle     = ($urandom_range(0, 4) != 0);
      rob_free_tag = 4'($urandom_range(1, 15));
      reg_rs1_tag  = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      reg_rs2_tag  = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      reg_rs1_data = $urandom();
      reg_rs2_data = $urandom();
      rob_q1_ready = 1'($urandom_range(0, 1));
      rob_q2_ready = 1'($urandom_range(0, 1));
      rob_q1_data  = $urandom();
      rob_q2_data  = $urandom();
      r = $urandom_range(0, 3);
      tag_renew = (r == 0) ? 4'd0 : (r == 1) ? reg_rs1_tag :
                  (r == 2) ? reg_rs2_tag : 4'($urandom_range(0, 15));
      data_renew = $urandom();
      e_acc = rdy && !clear && inst_valid && rob_idle &&
              (e_lsb ? (lsb_idle && !m_lsb) : (rs_idle && !m_rs));
      #1;
      checks++;
      if ({inst_ack, rob_issue, rename_en} !==
          {e_acc, e_acc, e_acc && (e_rd != 5'd0)}) begin
        errors++;
        $display("FAIL rand_accept cyc %0d got %b exp %b", c,
                 {inst_ack, rob_issue, rename_en},
                 {e_acc, e_acc, e_acc && (e_rd != 5'd0)});
      end
      if (e_acc) begin
        checks++;
        if ({rob_rd, rob_op, rename_tag} !== {e_rd, e_op, rob_free_tag})
        begin
          errors++;
          $display("FAIL rand_alloc cyc %0d got rd=%0d op=%0d tag=%0d exp %0d %0d %0d",
                   c, rob_rd, rob_op, rename_tag, e_rd, e_op, rob_free_tag);
        end
      end
      if (e_u1) begin
        checks++;
        if (reg_rs1_addr !== e_rs1 || rob_q1_tag !== reg_rs1_tag) begin
          errors++;
          $display("FAIL rand_rs1_lookup cyc %0d got %0d/%0d exp %0d/%0d",
                   c, reg_rs1_addr, rob_q1_tag, e_rs1, reg_rs1_tag);
        end
      end
      s1 = ref_src(e_u1, e_rs1, reg_rs1_tag, reg_rs1_data, tag_renew,
                   data_renew, rob_q1_ready, rob_q1_data);
      s2 = ref_src(e_u2, e_rs2, reg_rs2_tag, reg_rs2_data, tag_renew,
                   data_renew, rob_q2_ready, rob_q2_data);
      if (rdy) begin
        m_rs  = e_acc && !e_lsb;
        m_lsb = e_acc && e_lsb;
        if (e_acc) m_pkt = {rob_free_tag, e_op, s1, s2, e_imm, inst_pc};
      end
      @(posedge clk); #1;
      checks++;
      if ({if_issue_rs, if_issue_lsb, pkt_now} !== {m_rs, m_lsb, m_pkt})
      begin
        errors++;
        $display("FAIL rand_issue cyc %0d got %b%b %h exp %b%b %h", c,
                 if_issue_rs, if_issue_lsb, pkt_now, m_rs, m_lsb, m_pkt);
      end
    end
    @(negedge clk);
    set_idle();
  endtask

  initial begin
    set_idle();
    load_inst(K_BAD, 5'd0, 5'd0, 5'd0, 0);
    rst = 1'b1;
    test_reset();
    test_addi();
    test_add_dep();
    test_back_to_back();
    test_stall();
    test_clear();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
